// File: rtl/uart_tx_arq.sv
// Framed UART transmitter with serial acknowledge, timeout and bounded retransmission.
// Define UART_TX_ARQ_PARITY_EN to add an even-parity bit to the payload frame and to the ack word.
module uart_tx_arq #(
  parameter int unsigned          DATA_WIDTH   = 8,
  parameter int unsigned          CLKS_PER_BIT = 2604,
  parameter int unsigned          ACK_WIDTH    = 8,
  parameter logic [ACK_WIDTH-1:0] ACK_CODE     = 8'hCC,
  parameter int unsigned          ACK_TIMEOUT  = 500000,
  parameter int unsigned          MAX_RETX     = 5,
  parameter int unsigned          MSB_FIRST    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tx_valid,
  input  logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_ready,
  input  logic                            ack,
  output logic                            data_out,
  output logic                            busy,
  output logic                            done,
  output logic                            fail,
  output logic [$clog2(MAX_RETX+1)-1:0]   retx_count
);

`ifdef UART_TX_ARQ_PARITY_EN
  localparam int unsigned ACK_N = ACK_WIDTH + 1;
`else
  localparam int unsigned ACK_N = ACK_WIDTH;
`endif
  localparam int unsigned BMAX = (DATA_WIDTH > ACK_N) ? DATA_WIDTH : ACK_N;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW   = $clog2(ACK_TIMEOUT);
  localparam int unsigned RW   = $clog2(MAX_RETX+1);
  localparam int unsigned BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] ACK_LAST  = BW'(ACK_N - 1);
  localparam logic [RW-1:0] RETX_MAX  = RW'(MAX_RETX);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP,
    S_WAIT_ACK, S_ACK_START, S_ACK_BITS, S_RETRY
  } state_t;

  state_t                  state, next_state;
  logic [CW-1:0]           bit_cnt;
  logic [BW-1:0]           bit_idx;
  logic [TW-1:0]           tmo_cnt;
  logic [DATA_WIDTH-1:0]   hold_reg, shift_reg;
  logic [ACK_WIDTH-1:0]    ack_shift;
  logic                    bit_end, ack_ok, data_nx, done_nx, fail_nx;

  assign bit_end  = (bit_cnt == BIT_LAST);
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

`ifdef UART_TX_ARQ_PARITY_EN
  // On the final (parity) sample the ack word is already complete in ack_shift.
  assign ack_ok = (ack_shift == ACK_CODE) && ((^ack_shift) == ack);
`else
  assign ack_ok = (ACK_WIDTH'({ack_shift, ack}) == ACK_CODE);
`endif

  always_comb begin
    next_state = state;
    done_nx    = 1'b0;
    fail_nx    = 1'b0;
    data_nx    = 1'b1;
    case (state)
      S_IDLE:      if (tx_valid) next_state = S_START;
      S_START: begin
        data_nx = 1'b0;
        if (bit_end) next_state = S_DATA;
      end
      S_DATA: begin
        data_nx = (MSB_FIRST != 0) ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
        if (bit_end && (bit_idx == DATA_LAST)) begin
`ifdef UART_TX_ARQ_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        data_nx = ^hold_reg;
        if (bit_end) next_state = S_STOP;
      end
      S_STOP:      if (bit_end) next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!ack)                      next_state = S_ACK_START;
        else if (tmo_cnt == TMO_LAST)  next_state = S_RETRY;
      end
      S_ACK_START: if (bit_cnt == HALF_LAST) next_state = ack ? S_WAIT_ACK : S_ACK_BITS;
      S_ACK_BITS: begin
        if (bit_end && (bit_idx == ACK_LAST)) begin
          if (ack_ok) begin
            next_state = S_IDLE;
            done_nx    = 1'b1;
          end else begin
            next_state = S_RETRY;
          end
        end
      end
      S_RETRY: begin
        if (retx_count < RETX_MAX) begin
          next_state = S_START;
        end else begin
          next_state = S_IDLE;
          fail_nx    = 1'b1;
        end
      end
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      tmo_cnt    <= '0;
      hold_reg   <= '0;
      shift_reg  <= '0;
      ack_shift  <= '0;
      retx_count <= '0;
      data_out   <= 1'b1;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state    <= next_state;
      data_out <= data_nx;
      done     <= done_nx;
      fail     <= fail_nx;

      if ((next_state != state) || bit_end) bit_cnt <= '0;
      else                                  bit_cnt <= bit_cnt + 1'b1;

      if (next_state != state)
        bit_idx <= '0;
      else if (bit_end && ((state == S_DATA) || (state == S_ACK_BITS)))
        bit_idx <= bit_idx + 1'b1;

      // Runs on through ACK_START so a glitch on ack cannot stretch the window.
      if (state == S_STOP)
        tmo_cnt <= '0;
      else if (((state == S_WAIT_ACK) || (state == S_ACK_START)) && (tmo_cnt != TMO_LAST))
        tmo_cnt <= tmo_cnt + 1'b1;

      if ((state == S_IDLE) && tx_valid) begin
        hold_reg   <= tx_data;
        shift_reg  <= tx_data;
        retx_count <= '0;
      end else if ((state == S_RETRY) && (next_state == S_START)) begin
        shift_reg  <= hold_reg;
        retx_count <= retx_count + 1'b1;
      end else if ((state == S_DATA) && bit_end) begin
        shift_reg  <= (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
      end

      if ((state == S_ACK_BITS) && bit_end)
        ack_shift <= ACK_WIDTH'({ack_shift, ack});
    end
  end

endmodule

// File: tb/tb_uart_tx_arq.sv
// Directed self-checking bench for uart_tx_arq: framing, ack handling, retries, timeout and reset.
module tb_uart_tx_arq;
  localparam int CPB = 4;
`ifdef UART_TX_ARQ_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ack = 1'b1;
  logic       tx_valid_m = 1'b0, tx_valid_l = 1'b0;
  logic [7:0] tx_data_m = '0, tx_data_l = '0;
  logic       tx_ready_m, data_out_m, busy_m, done_m, fail_m;
  logic       tx_ready_l, data_out_l, busy_l, done_l, fail_l;
  logic [1:0] retx_m, retx_l;

  int unsigned n_chk = 0, n_err = 0;
  int unsigned done_cnt = 0, fail_cnt = 0, both_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_arq #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .ACK_WIDTH(8), .ACK_CODE(8'hCC),
                .ACK_TIMEOUT(50), .MAX_RETX(2), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_m), .tx_data(tx_data_m),
    .tx_ready(tx_ready_m), .ack(ack), .data_out(data_out_m), .busy(busy_m),
    .done(done_m), .fail(fail_m), .retx_count(retx_m));

  uart_tx_arq #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .ACK_WIDTH(8), .ACK_CODE(8'hCC),
                .ACK_TIMEOUT(50), .MAX_RETX(2), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_l), .tx_data(tx_data_l),
    .tx_ready(tx_ready_l), .ack(ack), .data_out(data_out_l), .busy(busy_l),
    .done(done_l), .fail(fail_l), .retx_count(retx_l));

  always @(negedge clk) begin
    if (done_m || done_l) done_cnt++;
    if (fail_m || fail_l) fail_cnt++;
    if ((done_m && fail_m) || (done_l && fail_l)) both_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int sel, input logic [7:0] d);
    if (sel == 1) begin
      tx_valid_l = 1'b1; tx_data_l = d; tick(); tx_valid_l = 1'b0;
      check("accept ready_drop", tx_ready_l, 0);
    end else begin
      tx_valid_m = 1'b1; tx_data_m = d; tick(); tx_valid_m = 1'b0;
      check("accept ready_drop", tx_ready_m, 0);
    end
  endtask

  // Starts right after the accept edge; leaves off on the frame's last stop-bit sample.
  task automatic capture_frame(input int sel, input logic [7:0] w, input bit msb, input string tag);
    logic            exp_b;
    logic [CPB-1:0]  s;
    for (int b = 0; b < NB; b++) begin
      if (b == 0)           exp_b = 1'b0;
      else if (b <= 8)      exp_b = msb ? w[8-b] : w[b-1];
      else if (b == NB - 1) exp_b = 1'b1;
      else                  exp_b = ^w;
      for (int c = 0; c < CPB; c++) begin
        tick();
        s[c] = (sel == 1) ? data_out_l : data_out_m;
      end
      check($sformatf("%s bit%0d", tag, b), s, {CPB{exp_b}});
    end
  endtask

  task automatic send_ack(input logic [7:0] w);
    ack = 1'b0;
    repeat (CPB) tick();
    for (int i = 7; i >= 0; i--) begin
      ack = w[i];
      repeat (CPB) tick();
    end
`ifdef UART_TX_ARQ_PARITY_EN
    ack = ^w;
    repeat (CPB) tick();
`endif
    ack = 1'b1;
  endtask

  task automatic idle_gap(input int n, input string tag);
    int lows = 0;
    repeat (n) begin
      tick();
      if (data_out_m == 1'b0) lows++;
    end
    check(tag, lows, 0);
  endtask

  task automatic wait_idle(input int sel, input int max_cycles, input string tag);
    int k = 0;
    while (((sel == 1) ? tx_ready_l : tx_ready_m) == 1'b0 && k < max_cycles) begin
      tick();
      k++;
    end
    check(tag, (sel == 1) ? tx_ready_l : tx_ready_m, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("rst data_out", data_out_m, 1);
    check("rst tx_ready", tx_ready_m, 1);
    check("rst busy", busy_m, 0);
    check("rst done_fail", {done_m, fail_m}, 0);
    check("rst retx", retx_m, 0);
    check("rst lsb idle", {tx_ready_l, data_out_l, busy_l}, 3'b110);

    // 1: MSB-first 0xA5, ack 0xCC two clocks after the stop bit
    accept(0, 8'hA5);
    check("t1 busy", busy_m, 1);
    check("t1 line_still_high", data_out_m, 1);
    capture_frame(0, 8'hA5, 1'b1, "t1");
    repeat (2) tick();
    send_ack(8'hCC);
    check("t1 ready_back", tx_ready_m, 1);
    check("t1 done_cnt", done_cnt, 1);
    check("t1 retx", retx_m, 0);
    check("t1 fail_cnt", fail_cnt, 0);

    // 2: LSB-first 0x01
    accept(1, 8'h01);
    capture_frame(1, 8'h01, 1'b0, "t2");
    repeat (2) tick();
    send_ack(8'hCC);
    wait_idle(1, 20, "t2 idle");
    check("t2 done_cnt", done_cnt, 2);
    check("t2 retx", retx_l, 0);

    // 3: no ack at all -> three frames, then fail
    accept(0, 8'h3C);
    capture_frame(0, 8'h3C, 1'b1, "t3 f0");
    idle_gap(51, "t3 gap0");
    check("t3 retx1", retx_m, 1);
    capture_frame(0, 8'h3C, 1'b1, "t3 f1");
    idle_gap(51, "t3 gap1");
    check("t3 retx2", retx_m, 2);
    capture_frame(0, 8'h3C, 1'b1, "t3 f2");
    idle_gap(50, "t3 gap2");
    check("t3 fail_not_early", {fail_m, busy_m}, 2'b01);
    tick();
    check("t3 fail_pulse", {fail_m, tx_ready_m}, 2'b11);
    tick();
    check("t3 fail_width", fail_m, 0);
    check("t3 fail_cnt", fail_cnt, 1);
    check("t3 done_cnt", done_cnt, 2);
    check("t3 retx_final", retx_m, 2);

    // 4: wrong ack then good ack; tx_data/tx_valid churn must not disturb the hold register
    accept(0, 8'h96);
    tx_valid_m = 1'b1; tx_data_m = 8'hFF;
    capture_frame(0, 8'h96, 1'b1, "t4 f0");
    repeat (2) tick();
    send_ack(8'h33);
    check("t4 retx", retx_m, 1);
    capture_frame(0, 8'h96, 1'b1, "t4 f1");
    tx_valid_m = 1'b0;
    repeat (2) tick();
    send_ack(8'hCC);
    check("t4 ready_back", tx_ready_m, 1);
    check("t4 done_cnt", done_cnt, 3);
    check("t4 retx_final", retx_m, 1);

    // 5: one-clock glitch on ack must not extend the timeout
    accept(0, 8'h5A);
    capture_frame(0, 8'h5A, 1'b1, "t5 f0");
    repeat (10) tick();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    repeat (38) tick();
    check("t5 no_early_retry", {busy_m, retx_m}, 3'b100);
    repeat (2) tick();
    check("t5 retry_on_time", retx_m, 1);
    capture_frame(0, 8'h5A, 1'b1, "t5 f1");
    repeat (2) tick();
    send_ack(8'hCC);
    check("t5 done_cnt", done_cnt, 4);

    // 6: reset mid-DATA and mid-ACK_BITS, then a clean transfer
    accept(0, 8'hC3);
    repeat (10) tick();
    do_reset();
    check("t6a idle", {data_out_m, busy_m, tx_ready_m}, 3'b101);
    repeat (5) tick();
    check("t6a no_pulse", {done_cnt[3:0], fail_cnt[3:0]}, {4'd4, 4'd1});
    accept(0, 8'h77);
    capture_frame(0, 8'h77, 1'b1, "t6b f0");
    repeat (2) tick();
    ack = 1'b0;
    repeat (CPB) tick();
    ack = 1'b1;
    repeat (8) tick();
    do_reset();
    check("t6b idle", {data_out_m, busy_m, tx_ready_m}, 3'b101);
    check("t6b retx", retx_m, 0);
    repeat (40) tick();
    check("t6b no_pulse", {done_cnt[3:0], fail_cnt[3:0]}, {4'd4, 4'd1});
    check("t6b stays_idle", busy_m, 0);
    accept(0, 8'hA5);
    capture_frame(0, 8'hA5, 1'b1, "t6c");
    repeat (2) tick();
    send_ack(8'hCC);
    check("t6c done_cnt", done_cnt, 5);
    check("t6c retx", retx_m, 0);
    check("never_done_and_fail", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
